// File: rtl/cp0_intc_if.sv
// cp0_intc_if: memory-stage bus between the pipeline and the CP0 interrupt controller
interface cp0_intc_if;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exccode_in;
    logic [5:0]  hwint;
    logic        eret;
    logic        take_exc;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;
    logic        exl;
    modport master (
        output we, addr, wdata, pc, bd, exccode_in, hwint, eret,
        input  rdata, take_exc, handler_pc, epc_out, exl
    );
    modport slave (
        input  we, addr, wdata, pc, bd, exccode_in, hwint, eret,
        output rdata, take_exc, handler_pc, epc_out, exl
    );
endinterface

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 SR/Cause/EPC/PrID registers, interrupt latching and trap decision
module cp0_intc #(
    parameter logic [31:0] PRID_VALUE   = 32'h4D495053,
    parameter logic [31:0] HANDLER_ADDR = 32'h00004180
) (
    input logic         clk,
    input logic         reset,
    cp0_intc_if.slave   bus
);
    logic [5:0]  im;
    logic        exl_r;
    logic        ie;
    logic        bd_r;
    logic [5:0]  ip;
    logic [4:0]  exc;
    logic [31:0] epc;
    logic [31:0] sr;
    logic [31:0] cause;
    logic        int_pend;
    logic        exc_pend;
    logic        take;

    assign sr       = {16'b0, im, 8'b0, exl_r, ie};
    assign cause    = {bd_r, 15'b0, ip, 3'b0, exc, 2'b0};
    assign int_pend = ie & ~exl_r & |(ip & im);
    assign exc_pend = (bus.exccode_in != 5'd0) & ~exl_r;
    assign take     = int_pend | exc_pend;

    always_comb begin
        bus.rdata = bus.addr == 5'd12 ? sr :
                    bus.addr == 5'd13 ? cause :
                    bus.addr == 5'd14 ? epc :
                    bus.addr == 5'd15 ? PRID_VALUE : 32'd0;
    end

    assign bus.take_exc   = take;
    assign bus.handler_pc = HANDLER_ADDR;
    assign bus.epc_out    = epc;
    assign bus.exl        = exl_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im    <= '0;
            exl_r <= 1'b0;
            ie    <= 1'b0;
            bd_r  <= 1'b0;
            ip    <= '0;
            exc   <= '0;
            epc   <= '0;
        end else begin
            ip <= bus.hwint;
            if (take) begin
                exl_r <= 1'b1;
                bd_r  <= bus.bd;
                exc   <= int_pend ? 5'd0 : bus.exccode_in;
                epc   <= bus.bd ? bus.pc - 32'd4 : bus.pc;
            end else begin
                if (bus.we && bus.addr == 5'd12) begin
                    im    <= bus.wdata[15:10];
                    exl_r <= bus.wdata[1];
                    ie    <= bus.wdata[0];
                end
                if (bus.we && bus.addr == 5'd14)
                    epc <= {bus.wdata[31:2], 2'b00};
                // eret wins over a same-cycle SR write of EXL
                if (bus.eret)
                    exl_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed self-checking bench for cp0_intc
module tb_cp0_intc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cmp = 0;
    int bad = 0;

    cp0_intc_if bus ();
    cp0_intc dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic idle;
        bus.we = 0; bus.addr = 5'd0; bus.wdata = 0; bus.pc = 0; bus.bd = 0;
        bus.exccode_in = 0; bus.eret = 0;
    endtask

    task automatic test_reset;
        logic [31:0] exp [4];
        exp[0] = 32'd0; exp[1] = 32'd0; exp[2] = 32'd0; exp[3] = 32'h4D495053;
        idle();
        bus.hwint = 6'h3F;
        cyc();
        for (int i = 0; i < 4; i++) begin
            bus.addr = 5'(12 + i);
            #1;
            cmp++;
            if (bus.rdata !== exp[i]) begin
                bad++;
                $display("FAIL reset_reg%0d got %h want %h", 12 + i, bus.rdata, exp[i]);
            end
        end
        cmp++;
        if (bus.exl !== 1'b0) begin bad++; $display("FAIL reset_exl got %b want 0", bus.exl); end
        reset = 0;
        cyc(); cyc();
        #1;
        cmp++;
        if (bus.take_exc !== 1'b0) begin bad++; $display("FAIL reset_take got %b want 0", bus.take_exc); end
    endtask

    task automatic test_interrupt;
        int n = 0;
        bus.hwint = 0; bus.we = 1; bus.addr = 5'd12; bus.wdata = 32'h0000_1001;
        cyc();
        idle();
        bus.hwint = 6'h04; bus.pc = 32'h0000_301C;
        #1;
        cmp++;
        if (bus.take_exc !== 1'b0) begin bad++; $display("FAIL int_latency got %b want 0", bus.take_exc); end
        for (int i = 1; i <= 6; i++) begin
            cyc();
            #1;
            n += int'(bus.take_exc);
            if (i == 1) begin
                cmp++;
                if (bus.take_exc !== 1'b1) begin bad++; $display("FAIL int_fire got %b want 1", bus.take_exc); end
            end
            if (i == 2) begin
                cmp++;
                if (bus.take_exc !== 1'b0) begin bad++; $display("FAIL int_drop got %b want 0", bus.take_exc); end
            end
        end
        cmp++;
        if (n != 1) begin bad++; $display("FAIL int_count got %0d want 1", n); end
        cmp++;
        if (bus.epc_out !== 32'h0000_301C) begin bad++; $display("FAIL int_epc got %h want 0000301c", bus.epc_out); end
        bus.addr = 5'd13;
        #1;
        cmp++;
        if (bus.rdata !== 32'h0000_1000) begin bad++; $display("FAIL int_cause got %h want 00001000", bus.rdata); end
        cmp++;
        if (bus.exl !== 1'b1) begin bad++; $display("FAIL int_exl got %b want 1", bus.exl); end
        bus.hwint = 0;
        cyc();
    endtask

    task automatic test_sync_exc;
        bus.exccode_in = 5'd4;
        #1;
        cmp++;
        if (bus.take_exc !== 1'b0) begin bad++; $display("FAIL exc_masked got %b want 0", bus.take_exc); end
        idle();
        bus.eret = 1;
        cyc();
        idle();
        #1;
        cmp++;
        if (bus.exl !== 1'b0) begin bad++; $display("FAIL eret_exl got %b want 0", bus.exl); end
        bus.exccode_in = 5'd12; bus.bd = 1; bus.pc = 32'h0000_3040;
        #1;
        cmp++;
        if (bus.take_exc !== 1'b1) begin bad++; $display("FAIL exc_same_cycle got %b want 1", bus.take_exc); end
        cyc();
        idle();
        bus.addr = 5'd13;
        #1;
        cmp++;
        if (bus.epc_out !== 32'h0000_303C) begin bad++; $display("FAIL exc_epc got %h want 0000303c", bus.epc_out); end
        cmp++;
        if (bus.rdata !== 32'h8000_0030) begin bad++; $display("FAIL exc_cause got %h want 80000030", bus.rdata); end
    endtask

    task automatic test_priority;
        bus.eret = 1;
        cyc();
        idle();
        bus.hwint = 6'h04;
        cyc();
        bus.exccode_in = 5'd4; bus.we = 1; bus.addr = 5'd14; bus.wdata = 32'hDEAD_0000; bus.pc = 32'h0000_5000;
        #1;
        cmp++;
        if (bus.take_exc !== 1'b1) begin bad++; $display("FAIL prio_take got %b want 1", bus.take_exc); end
        cyc();
        idle();
        bus.hwint = 0; bus.addr = 5'd13;
        #1;
        cmp++;
        if (bus.rdata !== 32'h0000_1000) begin bad++; $display("FAIL prio_cause got %h want 00001000", bus.rdata); end
        cmp++;
        if (bus.epc_out !== 32'h0000_5000) begin bad++; $display("FAIL prio_we_discard got %h want 00005000", bus.epc_out); end
    endtask

    task automatic test_eret_sr;
        bus.hwint = 6'h01;
        cyc();
        #1;
        cmp++;
        if (bus.take_exc !== 1'b0) begin bad++; $display("FAIL nest_masked got %b want 0", bus.take_exc); end
        bus.eret = 1; bus.we = 1; bus.addr = 5'd12; bus.wdata = 32'h0000_0403;
        cyc();
        idle();
        bus.addr = 5'd12; bus.pc = 32'h0000_6000;
        #1;
        cmp++;
        if (bus.rdata !== 32'h0000_0401) begin bad++; $display("FAIL eret_sr got %h want 00000401", bus.rdata); end
        cmp++;
        if (bus.take_exc !== 1'b1) begin bad++; $display("FAIL eret_refire got %b want 1", bus.take_exc); end
        cyc();
        idle();
        bus.hwint = 0;
        #1;
        cmp++;
        if (bus.exl !== 1'b1 || bus.epc_out !== 32'h0000_6000) begin
            bad++; $display("FAIL refire_commit got exl=%b epc=%h want 1 00006000", bus.exl, bus.epc_out);
        end
    endtask

    task automatic test_regs;
        cyc();
        bus.we = 1; bus.addr = 5'd14; bus.wdata = 32'h0000_3007;
        cyc();
        bus.we = 0;
        #1;
        cmp++;
        if (bus.rdata !== 32'h0000_3004) begin bad++; $display("FAIL epc_align got %h want 00003004", bus.rdata); end
        bus.we = 1; bus.addr = 5'd13; bus.wdata = 32'hFFFF_FFFF;
        cyc();
        bus.we = 0;
        #1;
        cmp++;
        if (bus.rdata !== 32'h0000_0000) begin bad++; $display("FAIL cause_ro got %h want 00000000", bus.rdata); end
        bus.we = 1; bus.addr = 5'd15; bus.wdata = 32'h0;
        cyc();
        bus.we = 0;
        #1;
        cmp++;
        if (bus.rdata !== 32'h4D49_5053) begin bad++; $display("FAIL prid_ro got %h want 4d495053", bus.rdata); end
        bus.addr = 5'd3;
        #1;
        cmp++;
        if (bus.rdata !== 32'h0) begin bad++; $display("FAIL unmapped got %h want 00000000", bus.rdata); end
        cmp++;
        if (bus.handler_pc !== 32'h0000_4180) begin bad++; $display("FAIL handler got %h want 00004180", bus.handler_pc); end
    endtask

    task automatic test_reset_mid;
        idle();
        bus.hwint = 6'h04;
        #1;
        cmp++;
        if (bus.exl !== 1'b1) begin bad++; $display("FAIL pre_reset_exl got %b want 1", bus.exl); end
        reset = 1;
        bus.addr = 5'd12;
        #1;
        cmp++;
        if (bus.rdata !== 32'h0 || bus.exl !== 1'b0 || bus.epc_out !== 32'h0 || bus.take_exc !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got sr=%h exl=%b epc=%h take=%b want all 0", bus.rdata, bus.exl, bus.epc_out, bus.take_exc);
        end
        cyc();
        reset = 0;
        bus.hwint = 0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_sync_exc();
        test_priority();
        test_eret_sr();
        test_regs();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
